frame_buffer_writer: RTL and testbench

// - Responder end of the rasterizer pixel-write interface: accepts (x,y,color) writes gated by frame_ready, buffers them,
//   and issues single-outstanding writes to pixel memory. Sits between the line generator and the external pixel RAM.
// - Double-buffers frames: the rasterizer draws the back bank while the display reads the front bank; swap at vsync after raster_done.

---
 rtl/fb_pkg.sv | 22 ++
 rtl/frame_buffer_writer_if.sv | 26 ++
 rtl/fb_wr_fifo.sv | 36 +++
 rtl/frame_buffer_writer.sv | 102 ++++++++++
 tb/tb_frame_buffer_writer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared constants, FSM state type, write-buffer entry and address helper for frame_buffer_writer
package fb_pkg;
  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int XY_W = 10;
  localparam int COLOR_W = 3;
  localparam int ADDR_W = 20;
  localparam int OFS_W = ADDR_W - 1;
  typedef enum logic [1:0] {RUN, DRAIN, WAIT_VSYNC} fb_state_t;
  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] color;
  } px_entry_t;
  // y*h_res+x; the 640-wide case is two shifts and adds instead of a multiplier
  function automatic logic [OFS_W-1:0] pix_offset(input logic [XY_W-1:0] x, input logic [XY_W-1:0] y, input int h_res);
    logic [OFS_W-1:0] xe, ye;
    xe = OFS_W'(x);
    ye = OFS_W'(y);
    return (h_res == 640) ? (ye << 9) + (ye << 7) + xe : ye * OFS_W'(h_res) + xe;
  endfunction
endpackage

// File: rtl/frame_buffer_writer_if.sv
// frame_buffer_writer_if: pixel-write handshake from the rasterizer plus the pixel-RAM write bus
//   px_wr_en/px_x/px_y/px_color  rasterizer -> writer, accepted when frame_ready=1
//   frame_ready                  writer -> rasterizer
//   mem_addr/mem_wdata/mem_we    writer -> pixel RAM, held until mem_ack
//   mem_ack                      pixel RAM -> writer
//   modport slave is the writer, modport master is the surrounding system
interface frame_buffer_writer_if;
  import fb_pkg::*;
  logic               px_wr_en;
  logic [XY_W-1:0]    px_x;
  logic [XY_W-1:0]    px_y;
  logic [COLOR_W-1:0] px_color;
  logic               frame_ready;
  logic [ADDR_W-1:0]  mem_addr;
  logic [COLOR_W-1:0] mem_wdata;
  logic               mem_we;
  logic               mem_ack;
  modport slave (
    input  px_wr_en, px_x, px_y, px_color, mem_ack,
    output frame_ready, mem_addr, mem_wdata, mem_we
  );
  modport master (
    output px_wr_en, px_x, px_y, px_color, mem_ack,
    input  frame_ready, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: synchronous FIFO for pending pixel writes
//   clk, rst (async, active-high), push/din write side, pop read side,
//   dout = head entry (valid when !empty), count = occupancy, empty
module fb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign dout = mem[rp];
  assign empty = (count == '0);
endmodule

// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer: buffers rasterizer pixel writes and issues them one at a time to pixel RAM,
// double-buffering frames when FB_DOUBLE_BUFFER_EN is defined (otherwise a single bank).
//   clk, rst (async, active-high)
//   bus          frame_buffer_writer_if.slave: pixel handshake + memory write bus
//   raster_done  level, frame finished drawing
//   vsync        one-cycle pulse at start of vertical blank (unused in single-bank build)
//   front_bank   bank read by the display
//   frame_swap   one-cycle pulse when the frame completes (with front_bank toggle if double-buffered)
//   drop_cnt     saturating count of out-of-range accepted writes
module frame_buffer_writer
  import fb_pkg::*;
#(
  parameter int H_RES = DEF_H_RES,
  parameter int V_RES = DEF_V_RES,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  frame_buffer_writer_if.slave bus,
  input  logic                 raster_done,
  input  logic                 vsync,
  output logic                 front_bank,
  output logic                 frame_swap,
  output logic [15:0]          drop_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fb_state_t state, state_next;
  logic raster_done_q, rise, in_range, accept, push, pop, empty, swap, back_bank;
  logic [CW-1:0] count, count_next;
  px_entry_t din, head;
  assign in_range = (bus.px_x < XY_W'(H_RES)) && (bus.px_y < XY_W'(V_RES));
  assign accept = bus.px_wr_en & bus.frame_ready;
  assign push = accept & in_range;
  assign pop = bus.mem_we & bus.mem_ack;
  assign rise = raster_done & ~raster_done_q;
  assign count_next = count + CW'(push) - CW'(pop);
  assign din = '{addr: {back_bank, pix_offset(bus.px_x, bus.px_y, H_RES)}, color: bus.px_color};
  fb_wr_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(px_entry_t))) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(din),
    .dout(head),
    .count(count),
    .empty(empty)
  );
  // The FIFO head is the outstanding request, so a push is visible on mem_* the next cycle
  // and stays put until the ack pops it.
  assign bus.mem_we = ~empty;
  assign bus.mem_addr = head.addr;
  assign bus.mem_wdata = head.color;
`ifdef FB_DOUBLE_BUFFER_EN
  logic bank_q;
  assign front_bank = bank_q;
  assign back_bank = ~bank_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) bank_q <= 1'b0;
    else if (swap) bank_q <= ~bank_q;
`else
  logic unused_vsync;
  assign unused_vsync = vsync;
  assign front_bank = 1'b0;
  assign back_bank = 1'b0;
`endif
  always_comb begin
    state_next = state;
    swap = 1'b0;
    case (state)
      RUN: state_next = rise ? DRAIN : RUN;
`ifdef FB_DOUBLE_BUFFER_EN
      DRAIN: state_next = empty ? WAIT_VSYNC : DRAIN;
      WAIT_VSYNC: begin
        state_next = vsync ? RUN : WAIT_VSYNC;
        swap = vsync;
      end
`else
      DRAIN: begin
        state_next = empty ? RUN : DRAIN;
        swap = empty;
      end
`endif
      default: state_next = RUN;
    endcase
  end
  // Ready looks at the next state and occupancy so it drops on the same edge that
  // enters DRAIN; the one slack entry absorbs the write accepted during the ready lag.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      raster_done_q <= 1'b0;
      bus.frame_ready <= 1'b0;
      frame_swap <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= state_next;
      raster_done_q <= raster_done;
      bus.frame_ready <= (state_next == RUN) && (count_next <= CW'(FIFO_DEPTH - 2));
      frame_swap <= swap;
      if (accept && !in_range && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
endmodule

// File: tb/tb_frame_buffer_writer.sv
// tb_frame_buffer_writer: directed + randomized checks of frame_buffer_writer against a queue-based pixel model
module tb_frame_buffer_writer;
  import fb_pkg::*;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  typedef struct {
    logic [19:0] a;
    logic [2:0]  c;
  } w_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raster_done = 1'b0;
  logic vsync = 1'b0;
  logic front_bank, frame_swap;
  logic [15:0] drop_cnt;
  int tests = 0;
  int fails = 0;
  int drops_exp = 0;
  int swaps = 0;
  int acc;
  logic front_exp = 1'b0;
  w_t q[$];
  frame_buffer_writer_if bus();
  frame_buffer_writer dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .raster_done(raster_done),
    .vsync(vsync),
    .front_bank(front_bank),
    .frame_swap(frame_swap),
    .drop_cnt(drop_cnt)
  );
  initial forever #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [19:0] exp_addr(input int x, input int y);
    int o;
    o = y * 640 + x;
    return {DB ? ~front_exp : 1'b0, o[18:0]};
  endfunction
  task automatic note(input int x, input int y, input logic [2:0] c);
    if (x < 640 && y < 480) q.push_back('{exp_addr(x, y), c});
    else drops_exp++;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int x, input int y, input logic [2:0] c);
    bit ok;
    ok = 1'b0;
    bus.px_x = 10'(x);
    bus.px_y = 10'(y);
    bus.px_color = c;
    bus.px_wr_en = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.frame_ready) begin
        note(x, y, c);
        ok = 1'b1;
      end
    end
    if (!ok) check("wr_timeout", 32'(bus.frame_ready), 1);
    cyc();
    bus.px_wr_en = 1'b0;
  endtask
  task automatic stream(input int n, input int mode, input bit wide, output int n_acc);
    int x, y;
    n_acc = 0;
    for (int i = 0; i < n; i++) begin
      x = wide ? $urandom_range(0, 699) : $urandom_range(0, 639);
      y = wide ? $urandom_range(0, 519) : $urandom_range(0, 479);
      bus.px_x = 10'(x);
      bus.px_y = 10'(y);
      bus.px_color = 3'($urandom);
      bus.px_wr_en = 1'b1;
      bus.mem_ack = (mode == 2) ? 1'($urandom) : 1'(mode);
      @(negedge clk);
      if (bus.frame_ready) begin
        note(x, y, bus.px_color);
        n_acc++;
      end
      cyc();
    end
    bus.px_wr_en = 1'b0;
  endtask
  task automatic drain();
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 200 && (q.size() != 0 || bus.mem_we); i++) cyc();
    check("drain_queue", q.size(), 0);
    check("drain_we", 32'(bus.mem_we), 0);
  endtask
  // memory-side monitor: every acknowledged write must be the oldest expected one, and a
  // request left unacknowledged must not change
  initial begin
    logic pend;
    logic [19:0] pa;
    logic [2:0] pc;
    w_t w;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) pend = 1'b0;
      else begin
        if (pend) begin
          check("hold_we", 32'(bus.mem_we), 1);
          check("hold_addr", 32'(bus.mem_addr), 32'(pa));
          check("hold_wdata", 32'(bus.mem_wdata), 32'(pc));
        end
        if (frame_swap) swaps++;
        if (bus.mem_we && bus.mem_ack) begin
          if (q.size() == 0) check("spurious_we", 32'(bus.mem_we), 0);
          else begin
            w = q.pop_front();
            check("wr_addr", 32'(bus.mem_addr), 32'(w.a));
            check("wr_data", 32'(bus.mem_wdata), 32'(w.c));
          end
        end
        pend = bus.mem_we && !bus.mem_ack;
        pa = bus.mem_addr;
        pc = bus.mem_wdata;
      end
    end
  end
  initial begin
    bus.px_wr_en = 1'b0;
    bus.px_x = '0;
    bus.px_y = '0;
    bus.px_color = '0;
    bus.mem_ack = 1'b0;
    repeat (3) cyc();
    check("rst_ready", 32'(bus.frame_ready), 0);
    check("rst_we", 32'(bus.mem_we), 0);
    check("rst_addr", 32'(bus.mem_addr), 0);
    check("rst_wdata", 32'(bus.mem_wdata), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    check("rst_front", 32'(front_bank), 0);
    check("rst_swap", 32'(frame_swap), 0);
    rst = 1'b0;
    cyc();
    check("ready_after_rst", 32'(bus.frame_ready), 1);
    // single write, immediate ack
    bus.mem_ack = 1'b1;
    wr(3, 2, 3'd5);
    check("first_we", 32'(bus.mem_we), 1);
    check("first_addr", 32'(bus.mem_addr), DB ? 32'h80503 : 32'h00503);
    check("first_wdata", 32'(bus.mem_wdata), 5);
    check("first_drop", 32'(drop_cnt), 0);
    repeat (2) cyc();
    // back-pressure: ack held low, strobe every cycle
    bus.mem_ack = 1'b0;
    stream(8, 0, 1'b0, acc);
    check("fill_accepted", acc, 3);
    check("fill_ready", 32'(bus.frame_ready), 0);
    check("fill_we", 32'(bus.mem_we), 1);
    drain();
    // range boundaries
    wr(640, 0, 3'd1);
    wr(0, 480, 3'd2);
    cyc();
    check("drop_two", 32'(drop_cnt), 2);
    check("drop_no_we", 32'(bus.mem_we), 0);
    wr(639, 479, 3'd7);
    check("max_offset", 32'(bus.mem_addr[18:0]), 307199);
    drain();
    // randomized traffic with random acks and out-of-range coordinates
    stream(60, 2, 1'b1, acc);
    drain();
    check("rand_drops", 32'(drop_cnt), drops_exp);
    // frame end with two writes queued
    bus.mem_ack = 1'b0;
    wr($urandom_range(0, 639), $urandom_range(0, 479), 3'($urandom));
    wr($urandom_range(0, 639), $urandom_range(0, 479), 3'($urandom));
    vsync = 1'b1;
    cyc();
    vsync = 1'b0;
    raster_done = 1'b1;
    cyc();
    check("drain_ready", 32'(bus.frame_ready), 0);
    stream(5, 0, 1'b0, acc);
    check("drain_accepted", acc, 0);
    drain();
    repeat (10) cyc();
    check("swaps_before_vsync", swaps, DB ? 0 : 1);
    check("front_before_vsync", 32'(front_bank), 0);
    vsync = 1'b1;
    cyc();
    vsync = 1'b0;
    front_exp = front_exp ^ DB;
    check("swap_pulse", 32'(frame_swap), 32'(DB));
    check("front_after_vsync", 32'(front_bank), 32'(front_exp));
    cyc();
    check("swap_one_cycle", 32'(frame_swap), 0);
    bus.mem_ack = 1'b1;
    wr($urandom_range(0, 639), $urandom_range(0, 479), 3'($urandom));
    check("bank0_write", 32'(bus.mem_addr[19]), 0);
    drain();
    // raster_done held high with vsync pulses: no retrigger
    for (int i = 0; i < 100; i++) begin
      vsync = (i % 7 == 3);
      cyc();
    end
    vsync = 1'b0;
    check("held_no_retrigger", swaps, 1);
    // rising edge coincident with vsync in RUN: edge wins
    raster_done = 1'b0;
    cyc();
    raster_done = 1'b1;
    vsync = 1'b1;
    cyc();
    vsync = 1'b0;
    repeat (10) cyc();
    check("edge_wins", swaps, DB ? 1 : 2);
    vsync = 1'b1;
    cyc();
    vsync = 1'b0;
    front_exp = front_exp ^ DB;
    cyc();
    check("second_swap", swaps, 2);
    check("front_second", 32'(front_bank), 32'(front_exp));
    raster_done = 1'b0;
    // reset with writes pending
    bus.mem_ack = 1'b0;
    wr(640, 1, 3'd0);
    wr($urandom_range(0, 639), $urandom_range(0, 479), 3'($urandom));
    wr($urandom_range(0, 639), $urandom_range(0, 479), 3'($urandom));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_we", 32'(bus.mem_we), 0);
    check("arst_front", 32'(front_bank), 0);
    check("arst_drop", 32'(drop_cnt), 0);
    check("arst_ready", 32'(bus.frame_ready), 0);
    q.delete();
    front_exp = 1'b0;
    drops_exp = 0;
    cyc();
    rst = 1'b0;
    cyc();
    bus.mem_ack = 1'b1;
    wr(10, 20, 3'd3);
    check("post_rst_addr", 32'(bus.mem_addr), DB ? 32'h8320A : 32'h0320A);
    drain();
    check("post_rst_drop", 32'(drop_cnt), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
